greater_serial: RTL and testbench

GREATER_SERIAL -- requirements
Module: greater_serial

---
 rtl/greater_pkg.sv | 18 +
 rtl/greater_digit.sv | 16 +
 rtl/greater_serial.sv | 112 +++++++++++
 tb/tb_greater_serial.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/greater_pkg.sv
// Shared FSM state encoding and result codes for the serial magnitude comparator.
package greater_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Result code bit order is {gt, eq, lt}; exactly one bit set once a result exists.
  typedef logic [2:0] result_t;

  localparam result_t RES_NONE = 3'b000;
  localparam result_t GT       = 3'b100;
  localparam result_t EQ       = 3'b010;
  localparam result_t LT       = 3'b001;

endpackage

// File: rtl/greater_digit.sv
// Combinational DIGIT-bit unsigned slice comparator.
module greater_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/greater_serial.sv
// Serial a-vs-b comparator, DIGIT bits per cycle MSB-first with early exit.
// Define GREATER_SIGNED_EN for two's-complement operands (default: unsigned).
module greater_serial
  import greater_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2   // WIDTH must be an integer multiple of DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int SLICES = WIDTH / DIGIT;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t           state_q, state_d;
  result_t          res_q, res_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_in, b_in;
  logic [CNT_W-1:0] cnt_q;
  logic             load, advance;
  logic             slice_gt, slice_eq, slice_lt;

  // Flipping the sign bit maps two's-complement order onto unsigned order;
  // it only ever lands in the most significant slice.
  always_comb begin
    a_in = a;
    b_in = b;
`ifdef GREATER_SIGNED_EN
    a_in[WIDTH-1] = ~a[WIDTH-1];
    b_in[WIDTH-1] = ~b[WIDTH-1];
`endif
  end

  // Operands shift left each cycle, so the slice under test is always the top one.
  greater_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_q[WIDTH-1 -: DIGIT]),
    .b  (b_q[WIDTH-1 -: DIGIT]),
    .gt (slice_gt),
    .eq (slice_eq),
    .lt (slice_lt)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPARE;
          res_d   = RES_NONE;
          load    = 1'b1;
        end
      end
      COMPARE: begin
        if (slice_gt) begin
          state_d = DONE;
          res_d   = GT;
        end else if (slice_lt) begin
          state_d = DONE;
          res_d   = LT;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = EQ;
        end else begin
          advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= RES_NONE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (load) begin
        a_q   <= a_in;
        b_q   <= b_in;
        cnt_q <= CNT_W'(SLICES - 1);
      end else if (advance) begin
        a_q   <= a_q << DIGIT;
        b_q   <= b_q << DIGIT;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign busy         = (state_q == COMPARE);
  assign done         = (state_q == DONE);
  assign {gt, eq, lt} = res_q;

endmodule

// File: tb/tb_greater_serial.sv
// Directed + random bench for greater_serial (WIDTH=8, DIGIT=2) with a result/latency scoreboard.
module tb_greater_serial;

  localparam int WIDTH  = 8;
  localparam int DIGIT  = 2;
  localparam int SLICES = WIDTH / DIGIT;
  localparam int BUDGET = 20;

  localparam logic [2:0] R_NONE = 3'b000;
  localparam logic [2:0] R_GT   = 3'b100;
  localparam logic [2:0] R_EQ   = 3'b010;
  localparam logic [2:0] R_LT   = 3'b001;

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy, done, gt, eq, lt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  greater_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word compare for the result, slice scan for the latency.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
`ifdef GREATER_SIGNED_EN
    if ($signed(x) > $signed(y))      e.res = R_GT;
    else if ($signed(x) < $signed(y)) e.res = R_LT;
    else                              e.res = R_EQ;
`else
    if (x > y)      e.res = R_GT;
    else if (x < y) e.res = R_LT;
    else            e.res = R_EQ;
`endif
    e.lat = SLICES;
    for (int s = SLICES - 1; s >= 0; s--) begin
      if (x[s*DIGIT +: DIGIT] != y[s*DIGIT +: DIGIT]) begin
        e.lat = SLICES - s;
        break;
      end
    end
    return e;
  endfunction

  // Called one step after a rising edge while the DUT is in IDLE.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [2:0] exp_res, input int exp_lat, input bit poke);
    exp_t e;
    int   lat;
    int   busy_n;
    bit   seen;
    e.res = exp_res;
    e.lat = exp_lat;
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_accept"}, busy, 1);
    check({tag, "_cleared"}, {gt, eq, lt}, R_NONE);
    busy_n = busy ? 1 : 0;
    lat    = 0;
    seen   = 1'b0;
    while (!seen && lat < BUDGET) begin
      if (poke && lat == 0) begin
        a     = ~x;
        b     = x;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
      if (sb.size() != 0) e = sb.pop_front();
      check({tag, "_result"}, {gt, eq, lt}, e.res);
      check({tag, "_latency"}, lat, e.lat);
      check({tag, "_busy_cycles"}, busy_n, e.lat);
      check({tag, "_busy_at_done"}, busy, 0);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_hold"}, {gt, eq, lt}, e.res);
    end
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] x, y;

    // Reset state
    #12;
    check("rst_outputs", {busy, done, gt, eq, lt}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First rising edge after reset release accepts start
`ifdef GREATER_SIGNED_EN
    run_op("c3_3c", 8'hC3, 8'h3C, R_LT, 1, 1'b0);
`else
    run_op("c3_3c", 8'hC3, 8'h3C, R_GT, 1, 1'b0);
`endif

    // Full-length equal, then back-to-back less-than decided in the last slice
    run_op("eq_5a", 8'h5A, 8'h5A, R_EQ, 4, 1'b0);
    run_op("lt_12_13", 8'h12, 8'h13, R_LT, 4, 1'b0);

    // Sign handling in the top slice
`ifdef GREATER_SIGNED_EN
    run_op("sign_80_01", 8'h80, 8'h01, R_LT, 1, 1'b0);
`else
    run_op("sign_80_01", 8'h80, 8'h01, R_GT, 1, 1'b0);
`endif

    // Start pulsed while busy must not disturb the running comparison
    run_op("poke_5a", 8'h5A, 8'h5A, R_EQ, 4, 1'b1);
    run_op("poke_mid", 8'h47, 8'h46, R_GT, 4, 1'b1);

    // Reset in the middle of COMPARE
    a     = 8'h5A;
    b     = 8'h5A;
    start = 1'b1;
    sb.push_back(model(8'h5A, 8'h5A));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {busy, done, gt, eq, lt}, 5'b0);
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", {busy, done}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 8'h10, 8'h20, R_LT, 2, 1'b0);

    // Random operands, a third of them differing in a single bit
    for (int i = 0; i < 16; i++) begin
      x = WIDTH'($urandom);
      y = (i % 3 == 0) ? (x ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1))) : WIDTH'($urandom);
      if (i == 5) y = x;
      e = model(x, y);
      run_op("rand", x, y, e.res, e.lat, 1'b0);
    end

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
